acq_timer_ctrl: RTL and testbench

Acquisition trigger scheduler that sequences the shared 32-bit free-running timer for one acquisition run. It clears and enables the timer, counts the timer's periodic tick pulses, and issues a trigger every PERIOD ticks. Each trigger carries a 32-bit timestamp and a sequence index. The run stops after a programmed trigger count or on a stop command. It sits between the host/control register block and the timer, and feeds the sample-capture logic.

---
 rtl/acq_timer_ctrl_if.sv | 32 +++
 rtl/acq_timer_ctrl.sv | 115 +++++++++++
 tb/tb_acq_timer_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_timer_ctrl_if.sv
// rtl/acq_timer_ctrl_if.sv - control, timer and trigger signals of the acquisition trigger scheduler
interface acq_timer_ctrl_if #(
   parameter int IDX_W  = 16,
   parameter int PER_W  = 16,
   parameter int WRAP_W = 8
) ();
   logic              start;
   logic              stop;
   logic [PER_W-1:0]  period;
   logic [IDX_W-1:0]  n_trig;
   logic              tick;
   logic [31:0]       tmr_count;
   logic              tmr_full;
   logic              tmr_clr;
   logic              tmr_ena;
   logic              trig;
   logic [31:0]       trig_ts;
   logic [IDX_W-1:0]  trig_idx;
   logic              busy;
   logic              done;
   logic [WRAP_W-1:0] wrap_cnt;

   modport master (
      output start, stop, period, n_trig, tick, tmr_count, tmr_full,
      input  tmr_clr, tmr_ena, trig, trig_ts, trig_idx, busy, done, wrap_cnt
   );

   modport slave (
      input  start, stop, period, n_trig, tick, tmr_count, tmr_full,
      output tmr_clr, tmr_ena, trig, trig_ts, trig_idx, busy, done, wrap_cnt
   );
endinterface

// File: rtl/acq_timer_ctrl.sv
// rtl/acq_timer_ctrl.sv - acquisition run scheduler: arms the shared timer and triggers every PERIOD ticks
module acq_timer_ctrl #(
   parameter int IDX_W  = 16,
   parameter int PER_W  = 16,
   parameter int WRAP_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   acq_timer_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]  IDX_ZERO = '0;
   localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
   localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

   logic [1:0]        state, state_nx;
   logic              accept, fire, tick_run;
   logic [PER_W-1:0]  per_q, tick_cnt;
   logic [IDX_W-1:0]  ntrig_q, trig_cnt;

   logic              tmr_clr_q, tmr_ena_q, trig_q, busy_q, done_q;
   logic [31:0]       trig_ts_q;
   logic [IDX_W-1:0]  trig_idx_q;
   logic [WRAP_W-1:0] wrap_cnt_q;

   // stop outranks a coincident tick, so a tick only counts when no stop is pending
   assign tick_run = (state == S_RUN) && !bus.stop && bus.tick;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      fire     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = S_ARM;
            end
         end
         S_ARM:  state_nx = S_RUN;
         S_RUN: begin
            if (bus.stop) begin
               state_nx = S_FIN;
            end else if (tick_run && (tick_cnt == per_q - PER_ONE)) begin
               fire = 1'b1;
               if ((ntrig_q != IDX_ZERO) && (trig_cnt == ntrig_q - IDX_ONE))
                  state_nx = S_FIN;
            end
         end
         S_FIN:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         per_q      <= '0;
         ntrig_q    <= '0;
         tick_cnt   <= '0;
         trig_cnt   <= '0;
         tmr_clr_q  <= 1'b0;
         tmr_ena_q  <= 1'b0;
         trig_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         trig_ts_q  <= '0;
         trig_idx_q <= '0;
         wrap_cnt_q <= '0;
      end else begin
         state     <= state_nx;
         tmr_clr_q <= (state_nx == S_ARM);
         tmr_ena_q <= (state_nx == S_RUN);
         busy_q    <= (state_nx == S_ARM) || (state_nx == S_RUN);
         done_q    <= (state_nx == S_FIN);
         trig_q    <= fire;

         if (accept) begin
            per_q      <= (bus.period == '0) ? PER_ONE : bus.period;
            ntrig_q    <= bus.n_trig;
            tick_cnt   <= '0;
            trig_cnt   <= '0;
            wrap_cnt_q <= '0;
         end

         if (tick_run)
            tick_cnt <= fire ? '0 : tick_cnt + PER_ONE;

         if (fire) begin
            trig_ts_q  <= bus.tmr_count;
            trig_idx_q <= trig_cnt;
            trig_cnt   <= trig_cnt + IDX_ONE;
         end

         if ((state == S_RUN) && bus.tmr_full && (wrap_cnt_q != WRAP_MAX))
            wrap_cnt_q <= wrap_cnt_q + WRAP_ONE;
      end
   end

   assign bus.tmr_clr  = tmr_clr_q;
   assign bus.tmr_ena  = tmr_ena_q;
   assign bus.trig     = trig_q;
   assign bus.trig_ts  = trig_ts_q;
   assign bus.trig_idx = trig_idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wrap_cnt = wrap_cnt_q;
endmodule

// File: tb/tb_acq_timer_ctrl.sv
// tb/tb_acq_timer_ctrl.sv - directed vector bench for acq_timer_ctrl
module tb_acq_timer_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   acq_timer_ctrl_if #(.IDX_W(16), .PER_W(16), .WRAP_W(8)) bus ();

   acq_timer_ctrl #(.IDX_W(16), .PER_W(16), .WRAP_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic        start;
      logic        stop;
      logic [15:0] period;
      logic [15:0] n_trig;
      logic        tick;
      logic [31:0] cnt;
      logic        clr;
      logic        ena;
      logic        trig;
      logic [31:0] ts;
      logic [15:0] idx;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vt[7];

   function automatic vec_t mkv(input logic st, input logic sp, input logic [15:0] per,
                                input logic [15:0] nt, input logic tk, input logic [31:0] c,
                                input logic clr, input logic ena, input logic tr,
                                input logic [31:0] ts, input logic [15:0] idx,
                                input logic bsy, input logic dn);
      vec_t v;
      v.start = st;  v.stop = sp;  v.period = per; v.n_trig = nt;
      v.tick = tk;   v.cnt = c;    v.clr = clr;    v.ena = ena;
      v.trig = tr;   v.ts = ts;    v.idx = idx;    v.busy = bsy; v.done = dn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] per, input logic [15:0] nt);
      bus.start  = 1'b1;
      bus.period = per;
      bus.n_trig = nt;
      step();
      bus.start  = 1'b0;
   endtask

   task automatic tick_at(input logic [31:0] c, input logic stp);
      bus.tick      = 1'b1;
      bus.tmr_count = c;
      bus.stop      = stp;
      step();
      bus.tick      = 1'b0;
      bus.stop      = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " clr"},  32'(bus.tmr_clr),  0);
      chk({tag, " ena"},  32'(bus.tmr_ena),  0);
      chk({tag, " trig"}, 32'(bus.trig),     0);
      chk({tag, " ts"},   bus.trig_ts,       0);
      chk({tag, " idx"},  32'(bus.trig_idx), 0);
      chk({tag, " busy"}, 32'(bus.busy),     0);
      chk({tag, " done"}, 32'(bus.done),     0);
      chk({tag, " wrap"}, 32'(bus.wrap_cnt), 0);
   endtask

   initial begin
      bus.start = 0; bus.stop = 0; bus.period = 0; bus.n_trig = 0;
      bus.tick = 0; bus.tmr_count = 0; bus.tmr_full = 0;

      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // period 0 acts as 1, stop alone in IDLE ignored, start wins over stop, ticks in ARM ignored
      vt[0] = mkv(0, 1, 0, 2, 0, 0,   0, 0, 0, 0,   0, 0, 0);
      vt[1] = mkv(1, 1, 0, 2, 0, 0,   1, 0, 0, 0,   0, 1, 0);
      vt[2] = mkv(0, 0, 0, 2, 1, 50,  0, 1, 0, 0,   0, 1, 0);
      vt[3] = mkv(0, 0, 0, 2, 1, 100, 0, 1, 1, 100, 0, 1, 0);
      vt[4] = mkv(0, 0, 0, 2, 1, 101, 0, 0, 1, 101, 1, 0, 1);
      vt[5] = mkv(0, 0, 0, 2, 1, 102, 0, 0, 0, 101, 1, 0, 0);
      vt[6] = mkv(0, 0, 0, 2, 0, 0,   0, 0, 0, 101, 1, 0, 0);
      for (int i = 0; i < 7; i++) begin
         bus.start = vt[i].start; bus.stop = vt[i].stop; bus.period = vt[i].period;
         bus.n_trig = vt[i].n_trig; bus.tick = vt[i].tick; bus.tmr_count = vt[i].cnt;
         step();
         chk($sformatf("v%0d clr", i),  32'(bus.tmr_clr),  32'(vt[i].clr));
         chk($sformatf("v%0d ena", i),  32'(bus.tmr_ena),  32'(vt[i].ena));
         chk($sformatf("v%0d trig", i), 32'(bus.trig),     32'(vt[i].trig));
         chk($sformatf("v%0d ts", i),   bus.trig_ts,       vt[i].ts);
         chk($sformatf("v%0d idx", i),  32'(bus.trig_idx), 32'(vt[i].idx));
         chk($sformatf("v%0d busy", i), 32'(bus.busy),     32'(vt[i].busy));
         chk($sformatf("v%0d done", i), 32'(bus.done),     32'(vt[i].done));
      end
      bus.start = 0; bus.stop = 0; bus.tick = 0;

      // period 3, four triggers, tick every 5 clocks
      pulse_start(3, 4);
      chk("t1 arm clr", 32'(bus.tmr_clr), 1);
      chk("t1 arm ena", 32'(bus.tmr_ena), 0);
      step();
      chk("t1 run clr", 32'(bus.tmr_clr), 0);
      chk("t1 run ena", 32'(bus.tmr_ena), 1);
      for (int t = 1; t <= 12; t++) begin
         repeat (4) begin
            step();
            chk("t1 gap trig", 32'(bus.trig), 0);
         end
         tick_at(32'(1000 + t * 7), 1'b0);
         if (t % 3 == 0) begin
            chk($sformatf("t1 trig %0d", t), 32'(bus.trig), 1);
            chk($sformatf("t1 idx %0d", t),  32'(bus.trig_idx), 32'(t / 3 - 1));
            chk($sformatf("t1 ts %0d", t),   bus.trig_ts, 32'(1000 + t * 7));
            chk($sformatf("t1 done %0d", t), 32'(bus.done), 32'(t == 12));
            chk($sformatf("t1 busy %0d", t), 32'(bus.busy), 32'(t != 12));
         end else begin
            chk($sformatf("t1 notrig %0d", t), 32'(bus.trig), 0);
         end
      end
      step();
      chk("t1 end done", 32'(bus.done), 0);
      chk("t1 end busy", 32'(bus.busy), 0);
      chk("t1 end ena",  32'(bus.tmr_ena), 0);

      // continuous mode, stop coincides with a qualifying tick
      pulse_start(2, 0);
      step();
      for (int k = 0; k < 20; k++) begin
         tick_at(32'(2000 + k), 1'b0);
         if (k % 2 == 1) begin
            chk($sformatf("t3 trig %0d", k), 32'(bus.trig), 1);
            chk($sformatf("t3 idx %0d", k),  32'(bus.trig_idx), 32'((k - 1) / 2));
            chk($sformatf("t3 ts %0d", k),   bus.trig_ts, 32'(2000 + k));
         end else begin
            chk($sformatf("t3 notrig %0d", k), 32'(bus.trig), 0);
         end
      end
      tick_at(3000, 1'b0);
      tick_at(3001, 1'b1);
      chk("t3 stop trig", 32'(bus.trig), 0);
      chk("t3 stop done", 32'(bus.done), 1);
      chk("t3 stop ena",  32'(bus.tmr_ena), 0);
      chk("t3 stop idx",  32'(bus.trig_idx), 9);
      step();
      chk("t3 after done", 32'(bus.done), 0);

      // start and period change mid-run are ignored
      pulse_start(2, 3);
      step();
      tick_at(10, 1'b0);
      tick_at(11, 1'b0);
      chk("t4 trig0 idx", 32'(bus.trig_idx), 0);
      pulse_start(1, 3);
      chk("t4 restart clr",  32'(bus.tmr_clr), 0);
      chk("t4 restart busy", 32'(bus.busy), 1);
      tick_at(12, 1'b0);
      chk("t4 spacing", 32'(bus.trig), 0);
      tick_at(13, 1'b0);
      chk("t4 trig1", 32'(bus.trig), 1);
      chk("t4 idx1",  32'(bus.trig_idx), 1);
      tick_at(14, 1'b0);
      tick_at(15, 1'b0);
      chk("t4 idx2",  32'(bus.trig_idx), 2);
      chk("t4 done",  32'(bus.done), 1);

      // wrap counter saturates, holds after the run, clears on next start
      step();
      pulse_start(1000, 0);
      bus.tmr_full = 1'b1;
      step();
      chk("t5 arm wrap", 32'(bus.wrap_cnt), 0);
      for (int p = 1; p <= 300; p++) begin
         step();
         if (p == 100) chk("t5 wrap100", 32'(bus.wrap_cnt), 100);
         if (p == 255) chk("t5 wrap255", 32'(bus.wrap_cnt), 255);
      end
      bus.tmr_full = 1'b0;
      chk("t5 wrap sat", 32'(bus.wrap_cnt), 255);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("t5 fin done", 32'(bus.done), 1);
      bus.tmr_full = 1'b1;
      step();
      step();
      bus.tmr_full = 1'b0;
      chk("t5 idle wrap", 32'(bus.wrap_cnt), 255);
      pulse_start(2, 0);
      chk("t5 cleared", 32'(bus.wrap_cnt), 0);

      // asynchronous reset between triggers
      step();
      tick_at(40, 1'b0);
      tick_at(41, 1'b0);
      chk("t6 pre idx", 32'(bus.trig_idx), 0);
      chk("t6 pre ts",  bus.trig_ts, 41);
      tick_at(42, 1'b0);
      tick_at(43, 1'b0);
      chk("t6 pre idx1", 32'(bus.trig_idx), 1);
      tick_at(44, 1'b0);
      #3 rst = 1'b0;
      #1;
      chk_all_zero("t6 async");
      repeat (2) begin
         step();
         chk("t6 rst done", 32'(bus.done), 0);
      end
      @(negedge clk);
      rst = 1'b1;
      pulse_start(2, 0);
      chk("t6 rearm clr", 32'(bus.tmr_clr), 1);
      step();
      chk("t6 run ena", 32'(bus.tmr_ena), 1);
      tick_at(70, 1'b0);
      tick_at(71, 1'b0);
      chk("t6 trig",  32'(bus.trig), 1);
      chk("t6 idx0",  32'(bus.trig_idx), 0);
      chk("t6 ts",    bus.trig_ts, 71);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
